// File: rtl/dcmi_receiver_pkg.sv
// dcmi_receiver_pkg
//   Definitions shared by the DCMI receiver and the DCMI transmitter:
//   default buffer geometry, the capture FSM state type and the
//   bundled DCMI bus used by the synchronizer pipeline.
//   No ports (package).
package dcmi_receiver_pkg;

    // Default buffer geometry, shared with the transmitter side.
    localparam int unsigned DCMI_LEN_BITS = 10;
    localparam int unsigned DCMI_MAX_LEN  = 1 << DCMI_LEN_BITS;

    // Capture FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StWaitLow,
        StRecv,
        StDone
    } rx_state_e;

    // One pipeline stage of the DCMI bus; all fields move together so the
    // data, frame strobe and clock keep their mutual alignment.
    typedef struct packed {
        logic [7:0] data;
        logic       dsync;
        logic       dclk;
    } dcmi_bus_t;

endpackage

// File: rtl/dcmi_sync.sv
// dcmi_sync
//   Brings the asynchronous DCMI bus into the Clk domain through one common
//   2-stage register pipeline and detects rising edges of DCLK.
//   Ports:
//     clk        in   system clock
//     rst        in   synchronous active-high reset
//     raw_data   in   DCMI data bus (8 bits)
//     raw_dsync  in   DCMI frame-valid strobe
//     raw_dclk   in   DCMI pixel clock, treated as data
//     sync_data  out  synchronized data, aligned with sync_dsync
//     sync_dsync out  synchronized frame-valid strobe
//     dclk_rise  out  one-cycle pulse on a synchronized DCLK rising edge
module dcmi_sync
    import dcmi_receiver_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] raw_data,
    input  logic       raw_dsync,
    input  logic       raw_dclk,
    output logic [7:0] sync_data,
    output logic       sync_dsync,
    output logic       dclk_rise
);

    dcmi_bus_t stage1_q;
    dcmi_bus_t stage2_q;
    logic      dclk_prev_q;

    // Everything resets to 0 so a low DCLK after reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage1_q    <= '0;
            stage2_q    <= '0;
            dclk_prev_q <= 1'b0;
        end else begin
            stage1_q    <= '{data: raw_data, dsync: raw_dsync, dclk: raw_dclk};
            stage2_q    <= stage1_q;
            dclk_prev_q <= stage2_q.dclk;
        end
    end

    // Edge pulse and the sampled data/strobe all come from stage 2.
    assign sync_data  = stage2_q.data;
    assign sync_dsync = stage2_q.dsync;
    assign dclk_rise  = stage2_q.dclk & ~dclk_prev_q;

endmodule

// File: rtl/dcmi_receiver.sv
// dcmi_receiver
//   Captures one DCMI frame (bytes sampled on DCLK rising edges while DSYNC is
//   high) into an on-chip buffer and holds it for readout until re-armed.
//   Ports:
//     Clk    in   system clock
//     RST    in   synchronous active-high reset
//     DATA   in   DCMI data bus (8 bits)
//     DSYNC  in   frame-valid strobe, high for the whole frame
//     DCLK   in   DCMI pixel clock, sampled as data
//     ARM    in   discard the held frame and re-enable capture
//     RD     in   advance the read pointer by one byte (only when READY)
//     DO     out  buffer byte at the read pointer, registered
//     READY  out  a complete frame is held in the buffer
//     LEN    out  captured byte count (LEN_BITS+1 bits), saturates at MAX_LEN
//     OVF    out  the frame carried more than MAX_LEN bytes
module dcmi_receiver
    import dcmi_receiver_pkg::*;
#(
    parameter int unsigned LEN_BITS = DCMI_LEN_BITS,
    parameter int unsigned MAX_LEN  = 1 << LEN_BITS
) (
    input  logic              Clk,
    input  logic              RST,
    input  logic [7:0]        DATA,
    input  logic              DSYNC,
    input  logic              DCLK,
    input  logic              ARM,
    input  logic              RD,
    output logic [7:0]        DO,
    output logic              READY,
    output logic [LEN_BITS:0] LEN,
    output logic              OVF
);

    localparam logic [LEN_BITS:0]   MaxCount = (LEN_BITS + 1)'(MAX_LEN);
    localparam logic [LEN_BITS:0]   CountOne = {{LEN_BITS{1'b0}}, 1'b1};
    localparam logic [LEN_BITS-1:0] LastAddr = LEN_BITS'(MAX_LEN - 1);
    localparam logic [LEN_BITS-1:0] AddrOne  = {{(LEN_BITS - 1){1'b0}}, 1'b1};

    logic [7:0] s_data;
    logic       s_dsync;
    logic       s_rise;

    rx_state_e           state_q, state_d;
    logic [LEN_BITS:0]   count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [LEN_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]          do_q;

    logic                we;
    logic [LEN_BITS-1:0] waddr;

    logic [7:0] ram [MAX_LEN];

    dcmi_sync u_sync (
        .clk        (Clk),
        .rst        (RST),
        .raw_data   (DATA),
        .raw_dsync  (DSYNC),
        .raw_dclk   (DCLK),
        .sync_data  (s_data),
        .sync_dsync (s_dsync),
        .dclk_rise  (s_rise)
    );

    always_ff @(posedge Clk) begin
        if (RST) begin
            state_q  <= StWaitLow;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        rd_ptr_d = rd_ptr_q;
        we       = 1'b0;
        waddr    = count_q[LEN_BITS-1:0];

        unique case (state_q)
            // Only start on a clean frame boundary: need DSYNC seen low first.
            StWaitLow: begin
                if (s_rise && !s_dsync) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (s_rise && s_dsync) begin
                    we      = 1'b1;
                    waddr   = '0;
                    count_d = CountOne;
                    state_d = StRecv;
                end
            end
            StRecv: begin
                if (s_rise) begin
                    if (s_dsync) begin
                        if (count_q == MaxCount) begin
                            ovf_d = 1'b1;
                        end else begin
                            we      = 1'b1;
                            count_d = count_q + CountOne;
                        end
                    end else begin
                        state_d  = StDone;
                        rd_ptr_d = '0;
                    end
                end
            end
            StDone: begin
                // Frame held; DSYNC activity is ignored until ARM.
                if (RD) begin
                    rd_ptr_d = (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + AddrOne;
                end
            end
            default: state_d = StWaitLow;
        endcase

        // ARM wins over any capture or frame end in the same cycle.
        if (ARM) begin
            state_d  = StWaitLow;
            count_d  = '0;
            ovf_d    = 1'b0;
            rd_ptr_d = '0;
            we       = 1'b0;
        end
    end

    // Buffer contents are deliberately not reset.
    always_ff @(posedge Clk) begin
        if (we) begin
            ram[waddr] <= s_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            do_q <= 8'h00;
        end else begin
            do_q <= ram[rd_ptr_q];
        end
    end

    assign DO    = do_q;
    assign READY = (state_q == StDone);
    assign LEN   = count_q;
    assign OVF   = ovf_q;

endmodule

// File: tb/tb_dcmi_receiver.sv
// tb_dcmi_receiver
//   Self-checking bench for dcmi_receiver. A behavioural DCMI source drives
//   frames; expected bytes are queued as they are sent and compared against
//   DO while the frame is read back.
module tb_dcmi_receiver;
    import dcmi_receiver_pkg::*;

    localparam int LB = DCMI_LEN_BITS;
    localparam int ML = 1 << LB;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic        dsync;
    logic        dclk;
    logic        arm;
    logic        rd;
    logic [7:0]  do_o;
    logic        ready;
    logic [LB:0] len;
    logic        ovf;

    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dcmi_receiver #(
        .LEN_BITS (LB),
        .MAX_LEN  (ML)
    ) dut (
        .Clk   (clk),
        .RST   (rst),
        .DATA  (data),
        .DSYNC (dsync),
        .DCLK  (dclk),
        .ARM   (arm),
        .RD    (rd),
        .DO    (do_o),
        .READY (ready),
        .LEN   (len),
        .OVF   (ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One DCMI clock period: low phase with new data, then the rising edge.
    task automatic dclk_edge(input logic [7:0] d, input logic s, input int phase);
        data  = d;
        dsync = s;
        dclk  = 1'b0;
        repeat (phase) tick();
        dclk = 1'b1;
        repeat (phase) tick();
    endtask

    // Sends tx_q as one frame framed by idle (DSYNC low) periods.
    task automatic send_frame(input int phase, input bit expect_cap);
        dclk_edge(8'h00, 1'b0, phase);
        dclk_edge(8'h00, 1'b0, phase);
        for (int i = 0; i < tx_q.size(); i++) begin
            dclk_edge(tx_q[i], 1'b1, phase);
            if (expect_cap && i < ML) exp_q.push_back(tx_q[i]);
        end
        dclk_edge(8'h00, 1'b0, phase);
        dclk_edge(8'h00, 1'b0, phase);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();  // let DO follow the zeroed read pointer
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
    endtask

    // Scoreboard drain: pop each expected byte, compare DO, advance with RD.
    task automatic drain(input string tag);
        logic [7:0] exp;
        int idx;
        idx = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_cmp++;
            if (do_o !== exp) begin
                n_err++;
                $display("FAIL %s byte %0d: DO=%02h expected %02h", tag, idx, do_o, exp);
            end
            rd = 1'b1;
            tick();
            rd = 1'b0;
            tick();
            idx++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp += 4;
        if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: %b expected 0", ready); end
        if (len !== '0)     begin n_err++; $display("FAIL reset_len: %0d expected 0", len); end
        if (ovf !== 1'b0)   begin n_err++; $display("FAIL reset_ovf: %b expected 0", ovf); end
        if (do_o !== 8'h00) begin n_err++; $display("FAIL reset_do: %02h expected 00", do_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(2, 1'b1);
        wait_ready(ok);
        n_cmp += 3;
        if (!ok)            begin n_err++; $display("FAIL basic_ready: READY=%b expected 1", ready); end
        if (int'(len) != 4) begin n_err++; $display("FAIL basic_len: %0d expected 4", len); end
        if (ovf !== 1'b0)   begin n_err++; $display("FAIL basic_ovf: %b expected 0", ovf); end
        drain("basic");
    endtask

    task automatic test_overflow();
        bit ok;
        logic [7:0] first;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        exp_q.delete();
        tx_q.delete();
        for (int i = 0; i < ML + 3; i++) tx_q.push_back(8'(i * 7 + 3));
        send_frame(1, 1'b1);
        wait_ready(ok);
        n_cmp += 3;
        if (!ok)             begin n_err++; $display("FAIL ovf_ready: READY=%b expected 1", ready); end
        if (int'(len) != ML) begin n_err++; $display("FAIL ovf_len: %0d expected %0d", len, ML); end
        if (ovf !== 1'b1)    begin n_err++; $display("FAIL ovf_flag: %b expected 1", ovf); end
        first = exp_q[0];
        drain("ovf");
        // Last RD stepped past MAX_LEN-1 and must have wrapped to address 0.
        n_cmp++;
        if (do_o !== first) begin
            n_err++;
            $display("FAIL ovf_wrap: DO=%02h expected %02h", do_o, first);
        end
    endtask

    task automatic test_done_ignore();
        bit ok;
        pulse_arm();
        tx_q = '{8'h05, 8'h06, 8'h07};
        send_frame(2, 1'b1);
        wait_ready(ok);
        tx_q = '{8'hAA, 8'hBB};
        send_frame(2, 1'b0);
        n_cmp += 2;
        if (!ok || ready !== 1'b1) begin n_err++; $display("FAIL ign_ready: %b expected 1", ready); end
        if (int'(len) != 3)        begin n_err++; $display("FAIL ign_len: %0d expected 3", len); end
        drain("ign");
        pulse_arm();
        n_cmp += 3;
        if (ready !== 1'b0) begin n_err++; $display("FAIL arm_ready: %b expected 0", ready); end
        if (len !== '0)     begin n_err++; $display("FAIL arm_len: %0d expected 0", len); end
        if (ovf !== 1'b0)   begin n_err++; $display("FAIL arm_ovf: %b expected 0", ovf); end
        tx_q = '{8'hCC};
        send_frame(2, 1'b1);
        wait_ready(ok);
        n_cmp += 2;
        if (!ok)            begin n_err++; $display("FAIL cc_ready: READY=%b expected 1", ready); end
        if (int'(len) != 1) begin n_err++; $display("FAIL cc_len: %0d expected 1", len); end
        drain("cc");
    endtask

    task automatic test_reset_midframe();
        bit ok;
        pulse_arm();
        dclk_edge(8'h00, 1'b0, 2);
        dclk_edge(8'h00, 1'b0, 2);
        dclk_edge(8'h31, 1'b1, 2);
        dclk_edge(8'h32, 1'b1, 2);
        dclk = 1'b0;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        dclk_edge(8'h33, 1'b1, 2);
        dclk_edge(8'h34, 1'b1, 2);
        dclk_edge(8'h35, 1'b1, 2);
        dclk_edge(8'h00, 1'b0, 2);
        dclk_edge(8'h00, 1'b0, 2);
        repeat (6) tick();
        n_cmp += 2;
        if (ready !== 1'b0) begin n_err++; $display("FAIL mid_ready: %b expected 0", ready); end
        if (len !== '0)     begin n_err++; $display("FAIL mid_len: %0d expected 0", len); end
        tx_q = '{8'h41, 8'h42, 8'h43};
        send_frame(2, 1'b1);
        wait_ready(ok);
        n_cmp += 2;
        if (!ok)            begin n_err++; $display("FAIL mid3_ready: READY=%b expected 1", ready); end
        if (int'(len) != 3) begin n_err++; $display("FAIL mid3_len: %0d expected 3", len); end
        drain("mid3");
    endtask

    task automatic test_arm_race();
        pulse_arm();
        dclk_edge(8'h00, 1'b0, 4);
        dclk_edge(8'h00, 1'b0, 4);
        dclk_edge(8'h51, 1'b1, 4);
        dclk_edge(8'h52, 1'b1, 4);
        // Frame-end edge; the detector sees it 2 Clk later, coinciding with ARM.
        data  = 8'h00;
        dsync = 1'b0;
        dclk  = 1'b0;
        repeat (4) tick();
        dclk = 1'b1;
        tick();
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (4) tick();
        n_cmp += 2;
        if (ready !== 1'b0) begin n_err++; $display("FAIL race_ready: %b expected 0", ready); end
        if (len !== '0)     begin n_err++; $display("FAIL race_len: %0d expected 0", len); end
        // In WAIT_LOW this frame has no leading low edge, so it must not capture.
        dclk_edge(8'h61, 1'b1, 2);
        dclk_edge(8'h62, 1'b1, 2);
        dclk_edge(8'h00, 1'b0, 2);
        repeat (6) tick();
        n_cmp++;
        if (ready !== 1'b0) begin n_err++; $display("FAIL race_wait_low: READY=%b expected 0", ready); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int d = 1; d <= 3; d += 2) begin
            pulse_arm();
            exp_q.delete();
            tx_q.delete();
            for (int i = 0; i < ML; i++) tx_q.push_back(8'(i));
            send_frame(1 << d, 1'b1);
            wait_ready(ok);
            n_cmp += 3;
            if (!ok)             begin n_err++; $display("FAIL b2b%0d_ready: READY=%b expected 1", d, ready); end
            if (int'(len) != ML) begin n_err++; $display("FAIL b2b%0d_len: %0d expected %0d", d, len, ML); end
            if (ovf !== 1'b0)    begin n_err++; $display("FAIL b2b%0d_ovf: %b expected 0", d, ovf); end
            drain($sformatf("b2b%0d", d));
        end
    endtask

    initial begin
        rst   = 1'b1;
        data  = 8'h00;
        dsync = 1'b0;
        dclk  = 1'b0;
        arm   = 1'b0;
        rd    = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_done_ignore();
        test_reset_midframe();
        test_arm_race();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
